// File: rtl/gated_logic_pkg.sv
// -----------------------------------------------------------------------------
// gated_logic_pkg
// Shared definitions for the gated_logic_pipe block: the opcode type and its
// encodings, plus the width of the optional parity sideband.
//
// Build option: define GATED_LOGIC_PARITY_EN to carry a parity bit alongside
// each result; PAR_W is 1 in that build and 0 otherwise.
// -----------------------------------------------------------------------------
package gated_logic_pkg;

    localparam int OP_W = 2;
    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND  = 2'b00;
    localparam op_t OP_OR   = 2'b01;
    localparam op_t OP_XOR  = 2'b10;
    localparam op_t OP_NAND = 2'b11;

`ifdef GATED_LOGIC_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

endpackage : gated_logic_pkg

// File: rtl/logic_pipe_stage.sv
// -----------------------------------------------------------------------------
// logic_pipe_stage
// One pipeline register: a DW-bit data word plus its valid bit. The valid bit
// and the data word have separate load enables, so the output stage can keep
// its last valid word while a bubble passes through.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_en_i   load valid_i into the valid bit
//   data_en_i    load data_i into the data word
//   valid_i      incoming valid
//   data_i       incoming data word
//   valid_o      registered valid
//   data_o       registered data word
// -----------------------------------------------------------------------------
module logic_pipe_stage
    import gated_logic_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_en_i,
    input  logic          data_en_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block leaves a variable unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_en_i) valid_d = valid_i;
        if (data_en_i)  data_d  = data_i;
    end

    // NOTE: the data word is reset as well as the valid bit: po_c must read
    // 0 out of reset, so this register cannot be left uninitialised.
    // NOTE: non-blocking assignments here so all stages update from the
    // pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : logic_pipe_stage

// File: rtl/gated_logic_pipe.sv
// -----------------------------------------------------------------------------
// gated_logic_pipe
// WIDTH-bit opcode-selectable bitwise logic unit behind a DEPTH-stage
// valid/ready pipeline, with a saturating count of delivered results.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pi_a, pi_b   operands (WIDTH)
//   pi_op        opcode: 00 AND, 01 OR, 10 XOR, 11 NAND
//   pi_flag      input valid strobe; accepted when pi_flag & po_rdy
//   po_rdy       block can accept input this cycle
//   pi_rdy       downstream ready
//   po_c         result (WIDTH), holds its last valid value while po_valid=0
//   po_valid     po_c valid
//   pi_clr       synchronous clear of po_cnt (wins over a transfer)
//   po_cnt       delivered-result count (CNT_W), saturating
//   po_par       even parity of po_c (only with GATED_LOGIC_PARITY_EN)
//
// Build option: GATED_LOGIC_PARITY_EN adds po_par; the parity bit is computed
// at stage 0 and travels with the data word.
// -----------------------------------------------------------------------------
module gated_logic_pipe
    import gated_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pi_a,
    input  logic [WIDTH-1:0] pi_b,
    input  logic [1:0]       pi_op,
    input  logic             pi_flag,
    output logic             po_rdy,
    input  logic             pi_rdy,
    output logic [WIDTH-1:0] po_c,
    output logic             po_valid,
    input  logic             pi_clr,
    output logic [CNT_W-1:0] po_cnt
`ifdef GATED_LOGIC_PARITY_EN
    ,
    output logic             po_par
`endif
);

    localparam int DW = WIDTH + PAR_W;

    // ---------------------------------------------------------------- opcode
    logic [WIDTH-1:0] op_res;
    logic [DW-1:0]    s0_data;

    always_comb begin
        op_res = '0;
        case (op_t'(pi_op))
            OP_AND:  op_res = pi_a & pi_b;
            OP_OR:   op_res = pi_a | pi_b;
            OP_XOR:  op_res = pi_a ^ pi_b;
            OP_NAND: op_res = ~(pi_a & pi_b);
            default: op_res = '0;
        endcase
    end

`ifdef GATED_LOGIC_PARITY_EN
    assign s0_data = {^op_res, op_res};
`else
    assign s0_data = op_res;
`endif

    // -------------------------------------------------------------- pipeline
    // The whole pipe advances together; it only stalls when the output holds
    // a valid result that downstream is refusing.
    logic en;
    assign en     = pi_rdy | ~po_valid;
    assign po_rdy = en;

    logic [DEPTH-1:0] stage_valid;
    logic [DW-1:0]    stage_data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          data_en;

        if (k == 0) begin : g_first
            assign in_valid = pi_flag;
            assign in_data  = s0_data;
        end else begin : g_next
            assign in_valid = stage_valid[k-1];
            assign in_data  = stage_data[k-1];
        end

        // Inner stages may load don't-care data on bubbles; the output stage
        // only loads real results so po_c never shows garbage.
        if (k == DEPTH - 1) begin : g_last
            assign data_en = en & in_valid;
        end else begin : g_mid
            assign data_en = en;
        end

        logic_pipe_stage #(.DW(DW)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid_en_i (en),
            .data_en_i  (data_en),
            .valid_i    (in_valid),
            .data_i     (in_data),
            .valid_o    (stage_valid[k]),
            .data_o     (stage_data[k])
        );
    end

    assign po_valid = stage_valid[DEPTH-1];
    assign po_c     = stage_data[DEPTH-1][WIDTH-1:0];
`ifdef GATED_LOGIC_PARITY_EN
    assign po_par   = stage_data[DEPTH-1][WIDTH];
`endif

    // --------------------------------------------------------------- counter
    logic             xfer;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign xfer = po_valid & pi_rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (pi_clr) begin
            cnt_d = '0;
        end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign po_cnt = cnt_q;

endmodule : gated_logic_pipe

// File: tb/tb_gated_logic_pipe.sv
// -----------------------------------------------------------------------------
// tb_gated_logic_pipe
// Self-checking bench for gated_logic_pipe (WIDTH=8, DEPTH=2, CNT_W=3).
// A scoreboard queue holds the results of accepted beats in order; every
// output beat, the hold value of po_c, po_rdy and the saturating count are
// compared against it. Directed sequences cover latency, the opcode table,
// backpressure, saturation/clear, asynchronous reset and parity.
// -----------------------------------------------------------------------------
module tb_gated_logic_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] pi_a, pi_b;
    logic [1:0]       pi_op;
    logic             pi_flag, pi_rdy, pi_clr;
    logic             po_rdy, po_valid;
    logic [WIDTH-1:0] po_c;
    logic [CNT_W-1:0] po_cnt;
`ifdef GATED_LOGIC_PARITY_EN
    logic             po_par;
`endif

    gated_logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pi_a     (pi_a),
        .pi_b     (pi_b),
        .pi_op    (pi_op),
        .pi_flag  (pi_flag),
        .po_rdy   (po_rdy),
        .pi_rdy   (pi_rdy),
        .po_c     (po_c),
        .po_valid (po_valid),
        .pi_clr   (pi_clr),
        .po_cnt   (po_cnt)
`ifdef GATED_LOGIC_PARITY_EN
        ,
        .po_par   (po_par)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ bookkeeping
    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q [$];
    int               cnt_m;
    logic [WIDTH-1:0] last_c;
    logic             last_acc;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // One clock cycle: observe handshakes just before the edge, update the
    // model, then check the registered outputs just after the edge.
    task automatic tick();
        logic rdy_exp;
        #1;
        rdy_exp = pi_rdy | ~po_valid;
        check("po_rdy", 64'(po_rdy), 64'(rdy_exp));
        if (po_valid && pi_rdy && exp_q.size() > 0) exp_q.delete(0);
        last_acc = pi_flag & rdy_exp;
        if (last_acc) exp_q.push_back(ref_op(pi_op, pi_a, pi_b));
        if (pi_clr)                               cnt_m = 0;
        else if (po_valid && pi_rdy && cnt_m < CNT_MAX) cnt_m++;
        @(posedge clk);
        #1;
        check("po_cnt", 64'(po_cnt), 64'(cnt_m));
        if (po_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(po_valid), 64'd0);
            end else begin
                check("po_c", 64'(po_c), 64'(exp_q[0]));
`ifdef GATED_LOGIC_PARITY_EN
                check("po_par", 64'(po_par), 64'(^exp_q[0]));
`endif
                last_c = exp_q[0];
            end
        end else begin
            check("po_c_hold", 64'(po_c), 64'(last_c));
`ifdef GATED_LOGIC_PARITY_EN
            check("po_par_hold", 64'(po_par), 64'(^last_c));
`endif
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] op, input logic flag);
        pi_a = a; pi_b = b; pi_op = op; pi_flag = flag;
    endtask

    task automatic clear_count();
        pi_clr = 1'b1;
        tick();
        pi_clr = 1'b0;
    endtask

    // --------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------ tests
    initial begin
        int k;
        int stall_cycles;
        logic pending;

        cnt_m = 0; last_c = '0; last_acc = 1'b0;
        rst_n = 1'b0; pi_rdy = 1'b0; pi_clr = 1'b0;
        drive('0, '0, 2'd0, 1'b0);

        // Reset state
        #12;
        check("rst_po_valid", 64'(po_valid), 64'd0);
        check("rst_po_c",     64'(po_c),     64'd0);
        check("rst_po_cnt",   64'(po_cnt),   64'd0);
        check("rst_po_rdy",   64'(po_rdy),   64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: one AND beat, visible exactly DEPTH cycles later
        pi_rdy = 1'b1;
        drive(8'hF0, 8'h3C, 2'd0, 1'b1);
        tick();
        pi_flag = 1'b0;
        check("lat_c1_valid", 64'(po_valid), 64'd0);
        tick();
        check("lat_c2_valid", 64'(po_valid), 64'd1);
        check("lat_c2_c",     64'(po_c),     64'h30);
        tick();
        check("lat_c3_valid", 64'(po_valid), 64'd0);
        check("lat_cnt",      64'(po_cnt),   64'd1);

        // All opcodes back-to-back from a table
        vecs[0] = '{a: 8'hAA, b: 8'h0F, op: 2'd0, exp: 8'h0A};
        vecs[1] = '{a: 8'hAA, b: 8'h0F, op: 2'd1, exp: 8'hAF};
        vecs[2] = '{a: 8'hAA, b: 8'h0F, op: 2'd2, exp: 8'hA5};
        vecs[3] = '{a: 8'hAA, b: 8'h0F, op: 2'd3, exp: 8'hF5};
        clear_count();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            else       pi_flag = 1'b0;
            tick();
            if (i >= DEPTH - 1 && i < DEPTH + 3) begin
                check("tbl_valid", 64'(po_valid), 64'd1);
                check("tbl_c",     64'(po_c),     64'(vecs[i-DEPTH+1].exp));
            end
        end
        check("tbl_cnt", 64'(po_cnt), 64'd4);

        // Backpressure: 4 beats, pi_rdy low for 3 cycles while po_valid=1
        clear_count();
        k = 0;
        stall_cycles = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            pi_rdy = !(cyc >= 2 && cyc <= 4);
            if (k < 4) drive(8'h11 * (k + 1), 8'h5A, k[1:0], 1'b1);
            else       pi_flag = 1'b0;
            if (!pi_rdy) begin
                #1;
                check("stall_rdy", 64'(po_rdy), 64'd0);
                check("stall_c",   64'(po_c),   64'(ref_op(2'd0, 8'h11, 8'h5A)));
                stall_cycles++;
            end
            tick();
            if (last_acc) k++;
        end
        check("bp_beats",  64'(k),             64'd4);
        check("bp_stalls", 64'(stall_cycles),  64'd3);
        check("bp_drain",  64'(exp_q.size()),  64'd0);
        check("bp_cnt",    64'(po_cnt),        64'd4);

        // Counter saturation, then clear colliding with a transfer
        pi_rdy = 1'b1;
        clear_count();
        for (int i = 0; i < 12; i++) begin
            drive(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)), i < 9);
            tick();
        end
        check("sat_cnt", 64'(po_cnt), 64'(CNT_MAX));
        drive(8'h3C, 8'hC3, 2'd2, 1'b1);
        tick();
        pi_flag = 1'b0;
        tick();
        check("clr_pre_valid", 64'(po_valid), 64'd1);
        pi_clr = 1'b1;
        tick();
        pi_clr = 1'b0;
        check("clr_wins", 64'(po_cnt), 64'd0);

        // Asynchronous reset with two beats in flight
        drive(8'h5A, 8'hFF, 2'd1, 1'b1);
        tick();
        drive(8'h12, 8'h34, 2'd2, 1'b1);
        tick();
        pi_flag = 1'b0;
        check("ar_pre_valid", 64'(po_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(po_valid), 64'd0);
        check("ar_c",     64'(po_c),     64'd0);
        check("ar_cnt",   64'(po_cnt),   64'd0);
        exp_q.delete();
        cnt_m = 0;
        last_c = '0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ar_post_valid", 64'(po_valid), 64'd0);
        end

`ifdef GATED_LOGIC_PARITY_EN
        // Parity: 07 | 00 = 07, odd number of ones
        drive(8'h07, 8'h00, 2'd1, 1'b1);
        tick();
        pi_flag = 1'b0;
        tick();
        check("par_c",   64'(po_c),   64'h07);
        check("par_bit", 64'(po_par), 64'd1);
`endif

        // Randomised traffic against the scoreboard; held inputs while stalled
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                drive(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
                pending = pi_flag;
            end
            pi_rdy = ($urandom_range(0, 3) != 0);
            pi_clr = ($urandom_range(0, 19) == 0);
            tick();
            if (last_acc) pending = 1'b0;
        end
        pi_flag = 1'b0;
        pi_clr  = 1'b0;
        pi_rdy  = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gated_logic_pipe
